// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Sequencer for the multi-cycle multiply and divide units.
//             Accepts a MULT/DIV command in IDLE, latches the operands,
//             holds the selected unit's level-sensitive enable for a fixed
//             number of cycles, then captures the unit's HI/LO result into
//             the architectural HI/LO registers. Also services direct HI/LO
//             writes (MTHI/MTLO) and rejects divide-by-zero.
//  Ports    :
//    Clock, Reset             - clock, synchronous active-high reset
//    Start, Op[1:0]           - command strobe, 01 = MULT, 10 = DIV
//    A, B                     - operands (DIV: A dividend, B divisor)
//    Hi_Write, Lo_Write       - direct write strobes for HI / LO
//    Write_Data               - data for direct writes
//    Mult_Control/Div_Control - registered unit enables
//    Unit_A, Unit_B           - latched operands fed to both units
//    Mult_HI/LO, Div_HI/LO    - unit results (Div_HI remainder, Div_LO quotient)
//    HI_Out, LO_Out           - architectural HI/LO registers
//    Busy                     - operation in progress (stall request)
//    Done                     - one-cycle pulse, HI_Out/LO_Out hold new result
//    Div_Zero                 - one-cycle pulse, DIV with B == 0 rejected
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 33,
    parameter int DIV_CYCLES  = 33,
    parameter int CNT_W       = 6
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Hi_Write,
    input  logic        Lo_Write,
    input  logic [31:0] Write_Data,
    output logic        Mult_Control,
    output logic        Div_Control,
    output logic [31:0] Unit_A,
    output logic [31:0] Unit_B,
    input  logic [31:0] Mult_HI,
    input  logic [31:0] Mult_LO,
    input  logic [31:0] Div_HI,
    input  logic [31:0] Div_LO,
    output logic [31:0] HI_Out,
    output logic [31:0] LO_Out,
    output logic        Busy,
    output logic        Done,
    output logic        Div_Zero
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_MULT = 2'd1,
        ST_RUN_DIV  = 2'd2,
        ST_CAPTURE  = 2'd3
    } state_t;

    localparam logic [1:0]       C_OP_MULT   = 2'b01;
    localparam logic [1:0]       C_OP_DIV    = 2'b10;
    localparam logic [CNT_W-1:0] C_MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [31:0]       unit_a_q,  unit_a_d;
    logic [31:0]       unit_b_q,  unit_b_d;
    logic [31:0]       hi_q,      hi_d;
    logic [31:0]       lo_q,      lo_d;
    logic              op_div_q,  op_div_d;
    logic              mult_en_q, mult_en_d;
    logic              div_en_q,  div_en_d;
    logic              done_q,    done_d;
    logic              dz_q,      dz_d;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            unit_a_q  <= '0;
            unit_b_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_div_q  <= 1'b0;
            mult_en_q <= 1'b0;
            div_en_q  <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            unit_a_q  <= unit_a_d;
            unit_b_q  <= unit_b_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_div_q  <= op_div_d;
            mult_en_q <= mult_en_d;
            div_en_q  <= div_en_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        unit_a_d  = unit_a_q;
        unit_b_d  = unit_b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_div_d  = op_div_q;
        mult_en_d = 1'b0;
        div_en_d  = 1'b0;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Direct writes land first; an accepted operation later
                // overwrites them at capture.
                if (Hi_Write) hi_d = Write_Data;
                if (Lo_Write) lo_d = Write_Data;

                if (Start && (Op == C_OP_MULT)) begin
                    unit_a_d  = A;
                    unit_b_d  = B;
                    cnt_d     = '0;
                    op_div_d  = 1'b0;
                    mult_en_d = 1'b1;
                    state_d   = ST_RUN_MULT;
                end else if (Start && (Op == C_OP_DIV)) begin
                    if (B == 32'd0) begin
                        dz_d = 1'b1;
                    end else begin
                        unit_a_d = A;
                        unit_b_d = B;
                        cnt_d    = '0;
                        op_div_d = 1'b1;
                        div_en_d = 1'b1;
                        state_d  = ST_RUN_DIV;
                    end
                end
            end

            // The enable was raised on the accepting edge; it stays high
            // until the edge where the counter reaches N-1, giving exactly
            // N enabled cycles.
            ST_RUN_MULT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_MULT_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    mult_en_d = 1'b1;
                end
            end

            ST_RUN_DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_DIV_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    div_en_d = 1'b1;
                end
            end

            ST_CAPTURE: begin
                hi_d    = op_div_q ? Div_HI : Mult_HI;
                lo_d    = op_div_q ? Div_LO : Mult_LO;
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Mult_Control = mult_en_q;
    assign Div_Control  = div_en_q;
    assign Unit_A       = unit_a_q;
    assign Unit_B       = unit_b_q;
    assign HI_Out       = hi_q;
    assign LO_Out       = lo_q;
    assign Busy         = (state_q != ST_IDLE);
    assign Done         = done_q;
    assign Div_Zero     = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Self-checking bench for muldiv_ctrl with behavioural
//             multiply/divide unit models whose results only become valid
//             after their enable has been high for the full latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int N = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] wdata = 32'd0;

    logic        mult_ctl, div_ctl, busy, done, div_zero;
    logic [31:0] unit_a, unit_b, mult_hi, mult_lo, div_hi, div_lo, hi_out, lo_out;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .MULT_CYCLES (N),
        .DIV_CYCLES  (N),
        .CNT_W       (6)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .Start        (start),
        .Op           (op),
        .A            (a),
        .B            (b),
        .Hi_Write     (hi_wr),
        .Lo_Write     (lo_wr),
        .Write_Data   (wdata),
        .Mult_Control (mult_ctl),
        .Div_Control  (div_ctl),
        .Unit_A       (unit_a),
        .Unit_B       (unit_b),
        .Mult_HI      (mult_hi),
        .Mult_LO      (mult_lo),
        .Div_HI       (div_hi),
        .Div_LO       (div_lo),
        .HI_Out       (hi_out),
        .LO_Out       (lo_out),
        .Busy         (busy),
        .Done         (done),
        .Div_Zero     (div_zero)
    );

    // Unit models: count consecutive enabled edges; a fresh rising enable
    // restarts the count. Output is garbage until N enabled cycles elapsed.
    logic [7:0]  m_cnt = 8'd0;
    logic [7:0]  d_cnt = 8'd0;
    logic        m_prev = 1'b0;
    logic        d_prev = 1'b0;
    logic [63:0] prod;

    always_ff @(posedge clk) begin
        m_prev <= mult_ctl;
        d_prev <= div_ctl;
        if (mult_ctl) m_cnt <= m_prev ? m_cnt + 8'd1 : 8'd1;
        if (div_ctl)  d_cnt <= d_prev ? d_cnt + 8'd1 : 8'd1;
    end

    assign prod    = {32'd0, unit_a} * {32'd0, unit_b};
    assign mult_hi = (m_cnt >= 8'(N)) ? prod[63:32] : 32'hBAD0_0001;
    assign mult_lo = (m_cnt >= 8'(N)) ? prod[31:0]  : 32'hBAD0_0002;
    assign div_hi  = (d_cnt >= 8'(N) && unit_b != 32'd0) ? unit_a % unit_b : 32'hBAD0_0003;
    assign div_lo  = (d_cnt >= 8'(N) && unit_b != 32'd0) ? unit_a / unit_b : 32'hBAD0_0004;

    int    n_vec = 0;
    int    n_err = 0;
    string tag   = "init";

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s_%s: got %0d, expected %0d", tag, nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s_%s: got 0x%08h, expected 0x%08h", tag, nm, act, exp);
        end
    endtask

    // Per-operation observations gathered by run_op
    int          done_at, done_n, men_n, men_first, men_last;
    int          den_n, den_first, den_last, busy_n, dz_at, dz_n;
    logic [31:0] hi_done, lo_done;

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        done_at = 0; done_n = 0; men_n = 0; men_first = 0; men_last = 0;
        den_n = 0; den_first = 0; den_last = 0; busy_n = 0; dz_at = 0; dz_n = 0;
        hi_done = 32'd0; lo_done = 32'd0;
        start = 1'b1; op = o; a = x; b = y;
        step();
        // Scramble inputs so any unintended re-latch is visible.
        start = 1'b0; op = 2'b00; a = 32'h5555_AAAA; b = 32'h1234_5678;
        for (int s = 1; s <= 40; s++) begin
            if (mult_ctl) begin
                men_n++;
                if (men_first == 0) men_first = s;
                men_last = s;
            end
            if (div_ctl) begin
                den_n++;
                if (den_first == 0) den_first = s;
                den_last = s;
            end
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = s; hi_done = hi_out; lo_done = lo_out;
                end
            end
            if (div_zero) begin
                dz_n++;
                if (dz_at == 0) dz_at = s;
            end
            step();
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    logic [31:0] hi_before, lo_before, ua_before, ub_before;
    logic        en_hist [1:80];
    int          d1, d2, b2b_done_n, z_idx, o_idx, found, n_late_done;
    logic [31:0] lo1, lo2, ua_mid, hi_keep, hi_mid;

    initial begin
        vecs[0] = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 1'b0};
        vecs[1] = '{2'b01, 32'h0010_0400, 32'h0000_0420, 32'h0000_0000, 32'h4210_8000, 1'b0};
        vecs[2] = '{2'b10, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
        vecs[3] = '{2'b10, 32'd5,         32'd0,         32'd0,         32'd0,         1'b1};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[5] = '{2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[6] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1;
        step(); step();
        tag = "reset";
        chki("mult_ctl", int'(mult_ctl), 0);
        chki("div_ctl",  int'(div_ctl),  0);
        chki("busy",     int'(busy),     0);
        chki("done",     int'(done),     0);
        chki("div_zero", int'(div_zero), 0);
        chkv("hi",       hi_out, 32'd0);
        chkv("lo",       lo_out, 32'd0);
        chkv("unit_a",   unit_a, 32'd0);
        chkv("unit_b",   unit_b, 32'd0);
        rst = 1'b0;
        step();

        // ---------------- table-driven operations ----------------
        for (int i = 0; i < NV; i++) begin
            tag       = $sformatf("v%0d", i);
            hi_before = hi_out;
            lo_before = lo_out;
            ua_before = unit_a;
            ub_before = unit_b;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b);
            if (vecs[i].dz) begin
                chki("dz_at",    dz_at, 1);
                chki("dz_n",     dz_n, 1);
                chki("done_n",   done_n, 0);
                chki("enables",  men_n + den_n, 0);
                chki("busy_n",   busy_n, 0);
                chkv("hi_kept",  hi_out, hi_before);
                chkv("lo_kept",  lo_out, lo_before);
                chkv("ua_kept",  unit_a, ua_before);
                chkv("ub_kept",  unit_b, ub_before);
            end else begin
                chki("done_at",  done_at, N + 2);
                chki("done_n",   done_n, 1);
                chki("busy_n",   busy_n, N + 1);
                chki("dz_n",     dz_n, 0);
                chkv("hi",       hi_done, vecs[i].hi);
                chkv("lo",       lo_done, vecs[i].lo);
                chkv("unit_a",   unit_a, vecs[i].a);
                chkv("unit_b",   unit_b, vecs[i].b);
                if (vecs[i].op == 2'b01) begin
                    chki("men_first", men_first, 1);
                    chki("men_last",  men_last, N);
                    chki("men_n",     men_n, N);
                    chki("den_n",     den_n, 0);
                end else begin
                    chki("den_first", den_first, 1);
                    chki("den_last",  den_last, N);
                    chki("den_n",     den_n, N);
                    chki("men_n",     men_n, 0);
                end
            end
        end

        // ---------------- back-to-back, Start held every cycle ----------------
        tag = "b2b";
        d1 = 0; d2 = 0; b2b_done_n = 0;
        lo1 = 32'd0; lo2 = 32'd0; ua_mid = 32'd0; hi_keep = 32'd0; hi_mid = 32'd0;
        start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
        step();
        a = 32'd9;
        wdata = 32'hDEAD_BEEF;
        for (int s = 1; s <= 75; s++) begin
            en_hist[s] = mult_ctl;
            if (done) begin
                b2b_done_n++;
                if (d1 == 0) begin
                    d1 = s; lo1 = lo_out;
                end else if (d2 == 0) begin
                    d2 = s; lo2 = lo_out;
                end
            end
            if (s == 9)  hi_keep = hi_out;
            if (s == 14) hi_mid  = hi_out;
            if (s == 20) ua_mid  = unit_a;
            hi_wr = (s >= 10 && s <= 12);
            if (s == 36) start = 1'b0;
            step();
        end
        hi_wr = 1'b0;
        z_idx = 0; o_idx = 0;
        for (int s = 1; s <= 75; s++) begin
            if (z_idx == 0 && !en_hist[s]) z_idx = s;
            else if (z_idx != 0 && o_idx == 0 && en_hist[s]) o_idx = s;
        end
        chki("first_done",  d1, N + 2);
        chkv("first_lo",    lo1, 32'd15);
        chki("second_done", d2, 2 * (N + 2));
        chkv("second_lo",   lo2, 32'd45);
        chki("done_n",      b2b_done_n, 2);
        chkv("ua_busy",     ua_mid, 32'd3);
        chkv("hi_busy_wr",  hi_mid, hi_keep);
        chki("en_fall",     z_idx, N + 1);
        chki("en_gap",      o_idx - z_idx, 2);

        // ---------------- direct writes in IDLE ----------------
        tag = "wr";
        hi_wr = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        hi_wr = 1'b0;
        chkv("hi", hi_out, 32'hDEAD_BEEF);
        lo_wr = 1'b1; wdata = 32'h1234_5678;
        step();
        lo_wr = 1'b0;
        chkv("lo",      lo_out, 32'h1234_5678);
        chkv("hi_hold", hi_out, 32'hDEAD_BEEF);

        // ---------------- Start together with Hi_Write ----------------
        tag = "start_wr";
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
        hi_wr = 1'b1; wdata = 32'hCAFE_F00D;
        step();
        start = 1'b0; hi_wr = 1'b0;
        chkv("hi_now", hi_out, 32'hCAFE_F00D);
        chki("busy",   int'(busy), 1);
        found = 0;
        for (int s = 2; s <= 40 && found == 0; s++) begin
            step();
            if (done) found = s;
        end
        chki("done_at", found, N + 2);
        chkv("hi",      hi_out, 32'd0);
        chkv("lo",      lo_out, 32'd6);

        // ---------------- Start accepted in the Div_Zero cycle ----------------
        tag = "dz_next";
        start = 1'b1; op = 2'b10; a = 32'd5; b = 32'd0;
        step();
        chki("dz",   int'(div_zero), 1);
        chki("busy", int'(busy), 0);
        a = 32'd9; b = 32'd4;
        step();
        start = 1'b0;
        chki("dz_clear", int'(div_zero), 0);
        chki("busy2",    int'(busy), 1);
        chki("div_ctl",  int'(div_ctl), 1);
        found = 0;
        for (int s = 2; s <= 40 && found == 0; s++) begin
            step();
            if (done) found = s;
        end
        chki("done_at", found, N + 2);
        chkv("hi",      hi_out, 32'd1);
        chkv("lo",      lo_out, 32'd2);

        // ---------------- reset in the middle of a MULT ----------------
        tag = "mid_rst";
        start = 1'b1; op = 2'b01; a = 32'd7; b = 32'd6;
        step();
        start = 1'b0;
        for (int s = 1; s < 10; s++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chki("mult_ctl", int'(mult_ctl), 0);
        chki("busy",     int'(busy), 0);
        chki("done",     int'(done), 0);
        chkv("hi",       hi_out, 32'd0);
        chkv("lo",       lo_out, 32'd0);
        chkv("unit_a",   unit_a, 32'd0);
        n_late_done = 0;
        for (int s = 12; s <= 40; s++) begin
            step();
            if (done || mult_ctl) n_late_done++;
        end
        chki("no_done", n_late_done, 0);
        run_op(2'b01, 32'd4, 32'd5);
        chki("after_done_at", done_at, N + 2);
        chki("after_men_n",   men_n, N);
        chkv("after_lo",      lo_done, 32'd20);
        chkv("after_hi",      hi_done, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
